// File: rtl/pixel_row_feeder.sv
// Credit-paced pixel row feeder: primes the line buffer with PRIME_ROWS rows, then sends one row per credit.
// Define FEEDER_PAD_EN to append two credit-paced rows of zero pixels after the last source row.
module pixel_row_feeder #(
  parameter int IMG_W      = 512,
  parameter int IMG_H      = 512,
  parameter int PRIME_ROWS = 4,
  parameter int CREDIT_MAX = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       row_done,
  output logic [7:0] pix_data,
  output logic       pix_valid,
  output logic       busy,
  output logic       done,
  output logic [2:0] credits
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = $clog2(IMG_H + 1);

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_TOTAL  = RW'(IMG_H);
  localparam logic [RW-1:0] ROW_PRIME  = RW'(PRIME_ROWS);
  localparam logic [2:0]    CREDIT_SAT = 3'(CREDIT_MAX);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
`ifdef FEEDER_PAD_EN
  localparam logic [2:0] S_PAD   = 3'd4;
  localparam logic [2:0] S_END   = S_PAD;
`else
  localparam logic [2:0] S_END   = S_IDLE;
`endif

  logic [2:0]    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [2:0]    credit_cnt;

  logic accept;
  logic col_last;
  logic row_last;
  logic prime_last;
  logic take_credit;
  logic credit_inc;
  logic src_end;
  logic emit;
  logic final_pix;

`ifdef FEEDER_PAD_EN
  logic pad_active;
  logic pad_row;
  logic pad_emit;
`endif

  // Upstream is only offered a slot while a row is being streamed in; reset holds it closed.
  assign s_ready    = !reset && ((state == S_PRIME) || (state == S_SEND));
  assign accept     = s_valid && s_ready;
  assign col_last   = (col == COL_LAST);
  assign row_last   = ((row + RW'(1)) == ROW_TOTAL);
  assign prime_last = ((row + RW'(1)) == ROW_PRIME);
  assign credit_inc = row_done && (state != S_IDLE);
  assign src_end    = accept && col_last && row_last;

`ifdef FEEDER_PAD_EN
  assign pad_emit    = (state == S_PAD) && pad_active;
  assign take_credit = (credit_cnt != 3'd0) &&
                       ((state == S_WAIT) || ((state == S_PAD) && !pad_active));
  assign emit        = accept || pad_emit;
  assign final_pix   = pad_emit && col_last && pad_row;
`else
  assign take_credit = (credit_cnt != 3'd0) && (state == S_WAIT);
  assign emit        = accept;
  assign final_pix   = src_end;
`endif

  assign credits = credit_cnt;
  assign busy    = (state != S_IDLE) || done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      credit_cnt <= 3'd0;
      pix_data   <= 8'd0;
      pix_valid  <= 1'b0;
      done       <= 1'b0;
`ifdef FEEDER_PAD_EN
      pad_active <= 1'b0;
      pad_row    <= 1'b0;
`endif
    end else begin
      pix_valid <= emit;
      pix_data  <= accept ? s_data : 8'd0;
      done      <= final_pix;

      // A credit arriving in the same cycle one is spent leaves the count unchanged.
      if (state == S_IDLE) begin
        if (start) credit_cnt <= 3'd0;
      end else if (credit_inc && !take_credit) begin
        if (credit_cnt != CREDIT_SAT) credit_cnt <= credit_cnt + 3'd1;
      end else if (take_credit && !credit_inc) begin
        credit_cnt <= credit_cnt - 3'd1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_PRIME;
            col   <= '0;
            row   <= '0;
`ifdef FEEDER_PAD_EN
            pad_active <= 1'b0;
            pad_row    <= 1'b0;
`endif
          end
        end

        S_PRIME: begin
          if (accept) begin
            if (col_last) begin
              col <= '0;
              row <= row + RW'(1);
              if (row_last)        state <= S_END;
              else if (prime_last) state <= S_WAIT;
            end else begin
              col <= col + CW'(1);
            end
          end
        end

        S_WAIT: begin
          if (credit_cnt != 3'd0) state <= S_SEND;
        end

        S_SEND: begin
          if (accept) begin
            if (col_last) begin
              col   <= '0;
              row   <= row + RW'(1);
              state <= row_last ? S_END : S_WAIT;
            end else begin
              col <= col + CW'(1);
            end
          end
        end

`ifdef FEEDER_PAD_EN
        // Each zero row waits for its own credit, then streams IMG_W pixels back to back.
        S_PAD: begin
          if (!pad_active) begin
            if (credit_cnt != 3'd0) pad_active <= 1'b1;
          end else if (col_last) begin
            col        <= '0;
            pad_active <= 1'b0;
            pad_row    <= 1'b1;
            if (pad_row) state <= S_IDLE;
          end else begin
            col <= col + CW'(1);
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_row_feeder.sv
// Scoreboard bench for pixel_row_feeder (IMG_W=4, IMG_H=6, PRIME_ROWS=4); honours FEEDER_PAD_EN.
module tb_pixel_row_feeder;

  localparam int IMG_W      = 4;
  localparam int IMG_H      = 6;
  localparam int PRIME_ROWS = 4;
  localparam int CREDIT_MAX = 7;

`ifdef FEEDER_PAD_EN
  localparam bit SRC_DONE = 1'b0;
`else
  localparam bit SRC_DONE = 1'b1;
`endif

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       start    = 1'b0;
  logic [7:0] s_data   = 8'd0;
  logic       s_valid  = 1'b0;
  logic       row_done = 1'b0;
  logic       s_ready;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       busy;
  logic       done;
  logic [2:0] credits;

  // Expected pixels: cyc is the cycle the pixel must appear in, or -1 for "next emitted pixel".
  typedef struct {
    int         cyc;
    logic [7:0] data;
    bit         last;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  bit         mon_v;
  bit         mon_last;
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] seed   = 8'h11;

  pixel_row_feeder #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .PRIME_ROWS(PRIME_ROWS),
    .CREDIT_MAX(CREDIT_MAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .row_done(row_done),
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .busy(busy),
    .done(done),
    .credits(credits)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks = checks + 1;
    if (actual != expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Called at a falling edge: drive one cycle, check s_ready, and book the pixel if it will be taken.
  task automatic applyStimulus(input bit v, input bit exp_ready, input bit rd, input bit last);
    exp_t e;
    s_valid  = v;
    s_data   = seed;
    row_done = rd;
    start    = 1'b0;
    checkOutput("s_ready", int'(s_ready), int'(exp_ready));
    if (v && exp_ready) begin
      e.cyc  = cyc + 1;
      e.data = seed;
      e.last = last;
      sb.push_back(e);
      seed = seed + 8'd37;
    end
    @(negedge clk);
    s_valid  = 1'b0;
    row_done = 1'b0;
  endtask

  task automatic startFrame();
    start    = 1'b1;
    s_valid  = 1'b0;
    row_done = 1'b0;
    checkOutput("s_ready_idle", int'(s_ready), 0);
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", int'(busy), 1);
    checkOutput("credits_at_start", int'(credits), 0);
  endtask

  task automatic primeFrame();
    startFrame();
    for (int i = 0; i < PRIME_ROWS * IMG_W; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("credits_in_wait", int'(credits), 0);
  endtask

  task automatic sendRow(input bit last_row, input bit stall);
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int acc = 0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    if (stall) begin
      for (int i = 0; i < 6; i++) begin
        applyStimulus(pat[i], 1'b1, 1'b0, last_row && SRC_DONE && pat[i] && (acc == IMG_W - 1));
        if (pat[i]) acc++;
      end
    end else begin
      for (int k = 0; k < IMG_W; k++)
        applyStimulus(1'b1, 1'b1, 1'b0, last_row && SRC_DONE && (k == IMG_W - 1));
    end
  endtask

  task automatic finishFrame();
    exp_t e;
`ifdef FEEDER_PAD_EN
    for (int k = 0; k < 2 * IMG_W; k++) begin
      e.cyc  = -1;
      e.data = 8'd0;
      e.last = (k == 2 * IMG_W - 1);
      sb.push_back(e);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (22) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pad_drained", sb.size(), 0);
`else
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
`endif
    checkOutput("busy_after_frame", int'(busy), 0);
  endtask

  // Output monitor: every cycle, pix_valid/pix_data/done must match the head of the scoreboard.
  always @(negedge clk) begin
    mon_v    = 1'b0;
    mon_last = 1'b0;
    if (sb.size() > 0 && (sb[0].cyc == cyc || (sb[0].cyc < 0 && pix_valid))) begin
      mon_e    = sb.pop_front();
      mon_v    = 1'b1;
      mon_last = mon_e.last;
      checkOutput("pix_data", int'(pix_data), int'(mon_e.data));
    end
    checkOutput("pix_valid", int'(pix_valid), int'(mon_v));
    checkOutput("done", int'(done), int'(mon_last));
    if (mon_last) checkOutput("busy_at_done", int'(busy), 1);
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("reset_pix_valid", int'(pix_valid), 0);
    checkOutput("reset_pix_data", int'(pix_data), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_s_ready", int'(s_ready), 0);
    checkOutput("reset_credits", int'(credits), 0);
    reset = 1'b0;

    // Frame 1: prime, one plain credited row, one row with an upstream stall pattern.
    primeFrame();
    sendRow(1'b0, 1'b0);
    checkOutput("credits_after_row", int'(credits), 0);
    sendRow(1'b1, 1'b1);
    finishFrame();

    // Frame 2: credit arriving at row start, then saturation while SEND is starved.
    primeFrame();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("credits_first_pulse", int'(credits), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("credits_simultaneous", int'(credits), 1);
    repeat (7) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("credits_saturated", int'(credits), CREDIT_MAX);
    for (int k = 0; k < IMG_W; k++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < IMG_W; k++) applyStimulus(1'b1, 1'b1, 1'b0, SRC_DONE && (k == IMG_W - 1));
    checkOutput("credits_after_frame", int'(credits), CREDIT_MAX - 1);
    finishFrame();

    // Frame 3: reset lands as the second pixel of a SEND row appears, then a clean restart.
    primeFrame();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    reset   = 1'b1;
    s_valid = 1'b1;
    #1;
    checkOutput("s_ready_during_reset", int'(s_ready), 0);
    @(negedge clk);
    s_valid = 1'b0;
    checkOutput("abort_pix_valid", int'(pix_valid), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_credits", int'(credits), 0);
    checkOutput("abort_pix_data", int'(pix_data), 0);
    reset = 1'b0;
    primeFrame();
    sendRow(1'b0, 1'b0);
    sendRow(1'b1, 1'b0);
    finishFrame();

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
